lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL expose: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: mem_read  input  1  core load request, from decode.
REQ-004 SHALL expose: mem_write  input  1  core store request, from decode.
REQ-005 SHALL expose: mem_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL expose: addr  input  32  effective byte address (ALU rs1+imm).
REQ-007 SHALL expose: wdata  input  32  store data (rs2).
REQ-008 SHALL expose: rdata  output  32  extended load result to writeback mux.
REQ-009 SHALL expose: stall  output  1  freeze PC/pipeline while high.
REQ-010 SHALL expose: access_fault  output  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-011 SHALL expose: bus_req, bus_we  output  1 each  memory request / write qualifier.
REQ-012 SHALL expose: bus_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-013 SHALL expose: bus_be  output  4  byte-lane enables; bus_wdata  output  32  lane-replicated store data.
REQ-014 SHALL expose: bus_ack  input  1  responder done; bus_rdata  input  32  read word, valid with bus_ack.
REQ-015 SHALL use parameter TIMEOUT, default 16, max bus wait cycles before abort.

Function
REQ-016 SHALL implement FSM IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE: request = mem_read|mem_write; if both high, write SHALL win and read be ignored.
REQ-018 Legality: W needs addr[1:0]=00; H/HU need addr[0]=0; loads with funct3 011/110/111 or stores with funct3 not in {000,001,010} are illegal.
REQ-019 IDLE, legal request: SHALL latch addr[1:0], funct3, we, bus_be, bus_wdata; stall=1 combinationally same cycle; next state BUSY.
REQ-020 IDLE, illegal/misaligned request: no bus transaction, access_fault=1 next cycle for exactly one cycle, stall=0, rdata=0.
REQ-021 Byte enables: B 0001<<addr[1:0]; H 0011<<{addr[1],1'b0}; W 1111; same encoding for loads.
REQ-022 Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-023 BUSY: bus_req=1, stall=1; bus_addr/bus_we/bus_be/bus_wdata SHALL remain stable until bus_ack.
REQ-024 BUSY with bus_ack: SHALL register load result, go DONE; bus_req deasserts the cycle after ack.
REQ-025 Load result: lane = bus_rdata >> (8*addr[1:0]) (latched offset); B/H sign-extend bit 7/15, BU/HU zero-extend, W unmodified; stores leave rdata 0.
REQ-026 BUSY cycle counter SHALL reset on BUSY entry; on reaching TIMEOUT without ack: abort, access_fault pulse 1 cycle, rdata=0, go DONE.
REQ-027 DONE: stall=0, rdata held valid; next state IDLE unconditionally (core retires instruction this edge).
REQ-028 Latency: ack in first BUSY cycle gives 2 stall cycles; each extra wait cycle adds 1.
REQ-029 bus_ack outside BUSY SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, stall=0, access_fault=0, rdata=0, counter=0.
REQ-031 Reset mid-BUSY SHALL abandon the transaction without fault pulse; first post-reset request starts fresh.

Verification
REQ-032 LB addr=0x103, bus_rdata=0x80FF_0000, ack 1st BUSY cycle -> bus_be=1000, bus_addr=0x100, rdata=0xFFFF_FF80, stall high 2 cycles.
REQ-033 SH addr=0x202, wdata=0x1234_ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, held stable over 3 wait cycles until ack.
REQ-034 LW addr=0x101 -> no bus_req, access_fault pulse 1 cycle, stall=0, rdata=0.
REQ-035 LHU addr=0x002, bus_ack never -> abort after 16 BUSY cycles, access_fault pulse, FSM returns IDLE.
REQ-036 mem_read=mem_write=1 SW addr=0x10 -> write issued, bus_we=1; assert rst_n low mid-BUSY -> all outputs 0 same cycle, IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: decodes core load/store requests into a
// single-outstanding word bus transaction, with alignment checks and a bus timeout.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // state | meaning
  // IDLE  | accept a new load/store; illegal requests fault without a bus cycle
  // BUSY  | bus_req held with stable address/lanes until ack or timeout
  // DONE  | result valid on rdata, core retires the instruction
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic          bus_req_q;
  logic          fault_q;
  logic [31:0]   rdata_q;
  logic [31:0]   bus_addr_q;
  logic [31:0]   bus_wdata_q;
  logic [3:0]    bus_be_q;

  logic          req;
  logic          f3_ok;
  logic          align_ok;
  logic          legal;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   lane;
  logic [31:0]   load_d;

  assign req = mem_read | mem_write;

  // A store decodes with store legality even when mem_read is also high.
  always_comb begin
    if (mem_write) begin
      f3_ok = mem_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_ok = mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (mem_funct3[1:0])
      2'b00: begin
        align_ok = 1'b1;
        be_d     = 4'b0001 << addr[1:0];
        wdata_d  = {4{wdata[7:0]}};
      end
      2'b01: begin
        align_ok = ~addr[0];
        be_d     = 4'b0011 << {addr[1], 1'b0};
        wdata_d  = {2{wdata[15:0]}};
      end
      default: begin
        align_ok = (addr[1:0] == 2'b00);
        be_d     = 4'b1111;
        wdata_d  = wdata;
      end
    endcase
    legal = f3_ok & align_ok;
  end

  assign lane = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_d = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_d = {24'b0, lane[7:0]};
      3'b001:  load_d = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_d = {16'b0, lane[15:0]};
      default: load_d = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      bus_req_q   <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (legal) begin
              off_q       <= addr[1:0];
              f3_q        <= mem_funct3;
              we_q        <= mem_write;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              bus_req_q   <= 1'b1;
              cnt_q       <= CNT_LOAD;
              state_q     <= S_BUSY;
            end else begin
              fault_q <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          // An ack arriving in the last allowed cycle still completes normally.
          if (bus_ack) begin
            rdata_q   <= we_q ? '0 : load_d;
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (cnt_q == '0) begin
            rdata_q   <= '0;
            fault_q   <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          rdata_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the PC freezes in the request cycle itself.
  assign stall = rst_n & (((state_q == S_IDLE) & req & legal) | (state_q == S_BUSY));

  assign rdata        = rdata_q;
  assign access_fault = fault_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, randomized transactions against
// a byte-level reference model, and hand-written reset/ack corner sequences.
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        access_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_funct3   (mem_funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .access_fault (access_fault),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          delay;   // BUSY cycles before ack; >= TIMEOUT means never
    logic [31:0] brd;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte lanes and extension from access size, offset and sign rules.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          sz;
    int          off;
    logic [31:0] val;
    r   = v;
    sz  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(v.addr[1:0]);
    if (v.wr) r.legal = (v.f3 <= 3'd2);
    else      r.legal = !(v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7);
    if ((off % sz) != 0) r.legal = 1'b0;
    r.be = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) r.wdat[8*i +: 8] = v.wd[8*(i % sz) +: 8];
    val = '0;
    if (r.legal) begin
      for (int i = 0; i < sz; i++) val[8*i +: 8] = v.brd[8*(off + i) +: 8];
      if (!v.f3[2] && sz < 4 && val[8*sz-1])
        for (int i = sz; i < 4; i++) val[8*i +: 8] = 8'hFF;
    end
    r.rdat = (v.wr || v.delay >= TIMEOUT) ? 32'h0 : val;
    return r;
  endfunction

  task automatic do_txn(input vec_t v, input string nm);
    int  k;
    int  stalls;
    bit  done;
    bit  tmo;
    tmo = (v.delay >= TIMEOUT);
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; mem_funct3 = v.f3;
    addr = v.addr; wdata = v.wd; bus_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_req_stall"}, 32'(stall), 32'(v.legal));
    chk({nm, "_req_busreq"}, 32'(bus_req), 32'h0);
    if (!v.legal) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk({nm, "_fault"}, 32'(access_fault), 32'h1);
      chk({nm, "_flt_stall"}, 32'(stall), 32'h0);
      chk({nm, "_flt_rdata"}, rdata, 32'h0);
      chk({nm, "_flt_busreq"}, 32'(bus_req), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_fault_end"}, 32'(access_fault), 32'h0);
    end else begin
      k = 0; stalls = 1; done = 0;
      while (!done && k < 40) begin
        @(posedge clk); #1;
        bus_ack   = (k == v.delay);
        bus_rdata = (k == v.delay) ? v.brd : $urandom;
        @(negedge clk);
        if (bus_req) begin
          if (stall) stalls++;
          chk({nm, "_b_stall"}, 32'(stall), 32'h1);
          chk({nm, "_b_addr"}, bus_addr, {v.addr[31:2], 2'b00});
          chk({nm, "_b_we"}, 32'(bus_we), 32'(v.wr));
          chk({nm, "_b_be"}, 32'(bus_be), 32'(v.be));
          chk({nm, "_b_wdata"}, bus_wdata, v.wdat);
          chk({nm, "_b_fault"}, 32'(access_fault), 32'h0);
          k++;
        end else begin
          done = 1;
          chk({nm, "_d_stall"}, 32'(stall), 32'h0);
          chk({nm, "_d_rdata"}, rdata, v.rdat);
          chk({nm, "_d_fault"}, 32'(access_fault), 32'(tmo));
        end
      end
      chk({nm, "_done_seen"}, 32'(done), 32'h1);
      chk({nm, "_stall_cycles"}, 32'(stalls), tmo ? 32'(TIMEOUT + 1) : 32'(v.delay + 2));
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
      @(negedge clk);
      chk({nm, "_i_stall"}, 32'(stall), 32'h0);
      chk({nm, "_i_fault"}, 32'(access_fault), 32'h0);
      chk({nm, "_i_rdata"}, rdata, 32'h0);
      chk({nm, "_i_busreq"}, 32'(bus_req), 32'h0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rdata"}, rdata, 32'h0);
    chk({nm, "_stall"}, 32'(stall), 32'h0);
    chk({nm, "_fault"}, 32'(access_fault), 32'h0);
    chk({nm, "_busreq"}, 32'(bus_req), 32'h0);
    chk({nm, "_buswe"}, 32'(bus_we), 32'h0);
    chk({nm, "_busbe"}, 32'(bus_be), 32'h0);
    chk({nm, "_busaddr"}, bus_addr, 32'h0);
    chk({nm, "_buswdata"}, bus_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];
  vec_t rv;
  int   sel;

  initial begin
    //               rd    wr    f3      addr       wd            dly brd            legal be       wdat           rdat
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        0,  32'h80FF_0000, 1'b1, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'h5555_5555, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h002, 32'h0,        99, 32'h0,         1'b1, 4'b1100, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0,        1,  32'h0000_F100, 1'b1, 4'b0010, 32'h0,         32'h0000_00F1};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h000, 32'h0,        2,  32'h0000_8001, 1'b1, 4'b0011, 32'h0,         32'hFFFF_8001};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h003, 32'h0000_00A5, 0, 32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b100, 32'h000, 32'h0,        0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h000, 32'h0,        0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h002, 32'h0,        0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h040, 32'h0,        15, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h003, 32'h0,        0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'b100, 32'h000, 32'h0,        0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_funct3 = 3'b000;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // bus_ack while idle must not start or complete anything
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ack%0d_busreq", i), 32'(bus_req), 32'h0);
      chk($sformatf("idle_ack%0d_fault", i), 32'(access_fault), 32'h0);
      chk($sformatf("idle_ack%0d_rdata", i), rdata, 32'h0);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;

    // both read and write high: the store wins, then reset aborts it mid-BUSY
    mem_read = 1'b1; mem_write = 1'b1; mem_funct3 = 3'b010;
    addr = 32'h10; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw_stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_busreq", 32'(bus_req), 32'h1);
    chk("rw_we", 32'(bus_we), 32'h1);
    chk("rw_be", 32'(bus_be), 32'hF);
    chk("rw_addr", bus_addr, 32'h10);
    chk("rw_wdata", bus_wdata, 32'hCAFE_F00D);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    chk_all_zero("midrst_hold");
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_fault", 32'(access_fault), 32'h0);
    chk("postrst_busreq", 32'(bus_req), 32'h0);
    rv = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 4'b0, 32'h0, 32'h0};
    do_txn(model(rv), "postrst_lw");

    for (int i = 0; i < 80; i++) begin
      sel      = $urandom_range(1, 3);
      rv.rd    = sel[0];
      rv.wr    = sel[1];
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.wd    = $urandom;
      rv.brd   = $urandom;
      rv.delay = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      do_txn(model(rv), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
